// File: rtl/ls_est_grouper.sv
// Packs serial DMRS LS channel estimates into 3-slot I/Q vectors for the averager.
// Groups close at the latched size (2 or 3) or early on in_last; unused slots are driven 0.
module ls_est_grouper #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_i,
  input  logic [DATA_WIDTH-1:0]   in_q,
  input  logic                    in_vld,
  input  logic                    in_last,
  input  logic                    cfg_group3,
  output logic [3*DATA_WIDTH-1:0] i_grouped,
  output logic [3*DATA_WIDTH-1:0] q_grouped,
  output logic [1:0]              parallel_mode,
  output logic                    out_vld,
  output logic                    seg_done,
  output logic [GCNT_WIDTH-1:0]   grp_cnt
);

  localparam int unsigned GW = 3 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_gsz3, w_gsz3_nxt;
  logic                  r_restart;
  logic [DATA_WIDTH-1:0] r_s0_i, r_s0_q, r_s1_i, r_s1_q;
  logic [DATA_WIDTH-1:0] w_s0_i_nxt, w_s0_q_nxt, w_s1_i_nxt, w_s1_q_nxt;
  logic                  w_close;
  logic [GW-1:0]         w_i_grp, w_q_grp;
  logic [1:0]            w_mode;
  logic [GCNT_WIDTH-1:0] w_gcnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Slot filling and group-close decode; group size is latched on the first sample.
  always_comb begin
    w_state_nxt = r_state;
    w_gsz3_nxt  = r_gsz3;
    w_s0_i_nxt  = r_s0_i;
    w_s0_q_nxt  = r_s0_q;
    w_s1_i_nxt  = r_s1_i;
    w_s1_q_nxt  = r_s1_q;
    w_close     = 1'b0;
    w_i_grp     = '0;
    w_q_grp     = '0;
    w_mode      = 2'b00;
    if (in_vld) begin
      case (r_state)
        ST_EMPTY: begin
          w_gsz3_nxt = cfg_group3;
          w_s0_i_nxt = in_i;
          w_s0_q_nxt = in_q;
          if (in_last) begin
            // Single-sample group: duplicate so a 2-input average returns s0.
            w_close = 1'b1;
            w_i_grp = {in_i, in_i, ZERO};
            w_q_grp = {in_q, in_q, ZERO};
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          w_s1_i_nxt = in_i;
          w_s1_q_nxt = in_q;
          if (in_last || !r_gsz3) begin
            w_close     = 1'b1;
            w_i_grp     = {r_s0_i, in_i, ZERO};
            w_q_grp     = {r_s0_q, in_q, ZERO};
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_TWO;
          end
        end
        ST_TWO: begin
          w_close     = 1'b1;
          w_i_grp     = {r_s0_i, r_s1_i, in_i};
          w_q_grp     = {r_s0_q, r_s1_q, in_q};
          w_mode      = 2'b01;
          w_state_nxt = ST_EMPTY;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
    if (r_restart)      w_gcnt_nxt = GCNT_WIDTH'(1);
    else if (&grp_cnt)  w_gcnt_nxt = grp_cnt;
    else                w_gcnt_nxt = grp_cnt + GCNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gsz3        <= 1'b1;
      r_restart     <= 1'b0;
      r_s0_i        <= '0;
      r_s0_q        <= '0;
      r_s1_i        <= '0;
      r_s1_q        <= '0;
      i_grouped     <= '0;
      q_grouped     <= '0;
      parallel_mode <= 2'b00;
      out_vld       <= 1'b0;
      seg_done      <= 1'b0;
      grp_cnt       <= '0;
    end else begin
      r_gsz3   <= w_gsz3_nxt;
      r_s0_i   <= w_s0_i_nxt;
      r_s0_q   <= w_s0_q_nxt;
      r_s1_i   <= w_s1_i_nxt;
      r_s1_q   <= w_s1_q_nxt;
      out_vld  <= w_close;
      seg_done <= w_close && in_last;
      if (w_close) begin
        i_grouped     <= w_i_grp;
        q_grouped     <= w_q_grp;
        parallel_mode <= w_mode;
        grp_cnt       <= w_gcnt_nxt;
        r_restart     <= in_last;
      end
    end
  end

endmodule

// File: tb/tb_ls_est_grouper.sv
// Scenario bench for ls_est_grouper: expected groups are queued as samples are driven
// and matched, including emission cycle, against groups the DUT produces.
module tb_ls_est_grouper;

  localparam int unsigned DW  = 16;
  localparam int unsigned GCW = 8;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   in_i, in_q;
  logic            in_vld, in_last, cfg_group3;
  logic [3*DW-1:0] i_grouped, q_grouped;
  logic [1:0]      parallel_mode;
  logic            out_vld, seg_done;
  logic [GCW-1:0]  grp_cnt;

  typedef struct packed {
    logic [3*DW-1:0] ig;
    logic [3*DW-1:0] qg;
    logic [1:0]      mode;
    logic            seg;
    logic [GCW-1:0]  gcnt;
    logic [31:0]     cyc;
  } grp_t;

  grp_t exp_q[$];
  grp_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  ls_est_grouper #(.DATA_WIDTH(DW), .GCNT_WIDTH(GCW)) dut (
    .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q), .in_vld(in_vld),
    .in_last(in_last), .cfg_group3(cfg_group3), .i_grouped(i_grouped),
    .q_grouped(q_grouped), .parallel_mode(parallel_mode), .out_vld(out_vld),
    .seg_done(seg_done), .grp_cnt(grp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int qv(input int i);
    return 500 - 3 * i;
  endfunction

  // One clock of stimulus; any group emitted at that edge is recorded with its cycle index.
  task automatic step(input logic vld, input int iv, input int qval, input logic last, input logic cfg);
    grp_t o;
    in_vld = vld; in_i = DW'(iv); in_q = DW'(qval); in_last = last; cfg_group3 = cfg;
    @(posedge clk); #1;
    cyc++;
    if (out_vld || seg_done) begin
      o.ig = i_grouped; o.qg = q_grouped; o.mode = parallel_mode;
      o.seg = seg_done; o.gcnt = grp_cnt; o.cyc = 32'(cyc);
      obs_q.push_back(o);
    end
  endtask

  task automatic send(input int iv, input logic last, input logic cfg);
    step(1'b1, iv, qv(iv), last, cfg);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input int a, input int b, input int c, input int qa, input int qb, input int qc,
                          input logic [1:0] m, input logic s, input int g);
    grp_t e;
    e.ig = {DW'(a), DW'(b), DW'(c)}; e.qg = {DW'(qa), DW'(qb), DW'(qc)};
    e.mode = m; e.seg = s; e.gcnt = GCW'(g); e.cyc = 32'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0; idle(); rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'(k % 2 == 0), k + 1, k + 2, 1'b0, 1'b1);
      checks++;
      if ({out_vld, seg_done, parallel_mode, grp_cnt, i_grouped, q_grouped} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: got vld=%b seg=%b mode=%b gcnt=%0d ig=%h qg=%h, required all 0",
                 k, out_vld, seg_done, parallel_mode, grp_cnt, i_grouped, q_grouped);
      end
    end
    rst = 1'b1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_novld: got %0d groups, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    grp_t e, o;
    logic [3*DW-1:0] hold_exp;
    for (int i = 1; i <= 6; i++) begin
      send(i, 1'b0, 1'b1);
      if (i % 3 == 0) push_exp(i - 2, i - 1, i, qv(i - 2), qv(i - 1), qv(i), 2'b01, 1'b0, i / 3);
    end
    idle();
    hold_exp = {DW'(4), DW'(5), DW'(6)};
    checks++;
    if (i_grouped !== hold_exp || out_vld !== 1'b0 || parallel_mode !== 2'b01) begin
      errors++;
      $display("FAIL b2b_hold: got ig=%h vld=%b mode=%b, required ig=%h vld=0 mode=01",
               i_grouped, out_vld, parallel_mode, hold_exp);
    end
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL b2b missing: got none, required ig=%h at cyc %0d", e.ig, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b group: got ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d, required ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d",
                   o.ig, o.qg, o.mode, o.seg, o.gcnt, o.cyc, e.ig, e.qg, e.mode, e.seg, e.gcnt, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL b2b extra: got %0d unexpected groups, required 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_group2_last();
    grp_t e, o;
    do_reset();
    step(1'b0, 99, 99, 1'b1, 1'b0);
    send(10, 1'b0, 1'b0);
    send(-20, 1'b0, 1'b0);
    push_exp(10, -20, 0, qv(10), qv(-20), 0, 2'b00, 1'b0, 1);
    send(30, 1'b0, 1'b0);
    send(-40, 1'b1, 1'b0);
    push_exp(30, -40, 0, qv(30), qv(-40), 0, 2'b00, 1'b1, 2);
    idle(); idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL g2 missing: got none, required ig=%h at cyc %0d", e.ig, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL g2 group: got ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d, required ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d",
                   o.ig, o.qg, o.mode, o.seg, o.gcnt, o.cyc, e.ig, e.qg, e.mode, e.seg, e.gcnt, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL g2 extra: got %0d unexpected groups, required 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_partial_dup();
    grp_t e, o;
    send(7, 1'b0, 1'b1);
    send(8, 1'b0, 1'b1);
    send(9, 1'b0, 1'b1);
    push_exp(7, 8, 9, qv(7), qv(8), qv(9), 2'b01, 1'b0, 1);
    send(11, 1'b1, 1'b1);
    push_exp(11, 11, 0, qv(11), qv(11), 0, 2'b00, 1'b1, 2);
    idle(); idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL dup missing: got none, required ig=%h at cyc %0d", e.ig, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL dup group: got ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d, required ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d",
                   o.ig, o.qg, o.mode, o.seg, o.gcnt, o.cyc, e.ig, e.qg, e.mode, e.seg, e.gcnt, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL dup extra: got %0d unexpected groups, required 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_cfg_flip();
    grp_t e, o;
    send(21, 1'b0, 1'b1);
    send(22, 1'b0, 1'b0);
    send(23, 1'b0, 1'b0);
    push_exp(21, 22, 23, qv(21), qv(22), qv(23), 2'b01, 1'b0, 1);
    send(24, 1'b0, 1'b0);
    send(25, 1'b0, 1'b1);
    push_exp(24, 25, 0, qv(24), qv(25), 0, 2'b00, 1'b0, 2);
    send(26, 1'b1, 1'b0);
    push_exp(26, 26, 0, qv(26), qv(26), 0, 2'b00, 1'b1, 3);
    send(27, 1'b0, 1'b1);
    send(28, 1'b1, 1'b0);
    push_exp(27, 28, 0, qv(27), qv(28), 0, 2'b00, 1'b1, 1);
    idle(); idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL flip missing: got none, required ig=%h at cyc %0d", e.ig, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL flip group: got ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d, required ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d",
                   o.ig, o.qg, o.mode, o.seg, o.gcnt, o.cyc, e.ig, e.qg, e.mode, e.seg, e.gcnt, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL flip extra: got %0d unexpected groups, required 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    grp_t e, o;
    send(31, 1'b0, 1'b1);
    send(32, 1'b0, 1'b1);
    do_reset();
    send(33, 1'b0, 1'b1);
    send(34, 1'b0, 1'b1);
    send(35, 1'b0, 1'b1);
    push_exp(33, 34, 35, qv(33), qv(34), qv(35), 2'b01, 1'b0, 1);
    idle(); idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rstmid missing: got none, required ig=%h at cyc %0d", e.ig, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL rstmid group: got ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d, required ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d",
                   o.ig, o.qg, o.mode, o.seg, o.gcnt, o.cyc, e.ig, e.qg, e.mode, e.seg, e.gcnt, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rstmid extra: got %0d unexpected groups, required 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_saturate();
    grp_t e, o;
    do_reset();
    for (int k = 1; k <= 257; k++) begin
      send(k, 1'b0, 1'b0);
      send(k + 1000, 1'b0, 1'b0);
      push_exp(k, k + 1000, 0, qv(k), qv(k + 1000), 0, 2'b00, 1'b0, (k > 255) ? 255 : k);
    end
    send(2000, 1'b0, 1'b0);
    send(2001, 1'b1, 1'b0);
    push_exp(2000, 2001, 0, qv(2000), qv(2001), 0, 2'b00, 1'b1, 255);
    send(3000, 1'b1, 1'b0);
    push_exp(3000, 3000, 0, qv(3000), qv(3000), 0, 2'b00, 1'b1, 1);
    idle(); idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL sat missing: got none, required ig=%h at cyc %0d", e.ig, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL sat group: got ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d, required ig=%h qg=%h mode=%b seg=%b gcnt=%0d cyc=%0d",
                   o.ig, o.qg, o.mode, o.seg, o.gcnt, o.cyc, e.ig, e.qg, e.mode, e.seg, e.gcnt, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL sat extra: got %0d unexpected groups, required 0", obs_q.size()); obs_q.delete();
    end
  endtask

  initial begin
    rst = 1'b0; in_vld = 1'b0; in_last = 1'b0; cfg_group3 = 1'b0; in_i = '0; in_q = '0;
    test_reset();
    test_back_to_back();
    test_group2_last();
    test_partial_dup();
    test_cfg_flip();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
